// File: rtl/game_pkg.sv
// Shared definitions for the game core: round FSM encoding, level and
// speed codes, and the level-to-speed mapping.
package game_pkg;

  typedef enum logic [1:0] {
    S_Idle  = 2'd0,
    S_Run   = 2'd1,
    S_Pause = 2'd2,
    S_Done  = 2'd3
  } state_t;

  localparam logic [1:0] LVL_NORMAL = 2'd0;
  localparam logic [1:0] LVL_INTER  = 2'd1;
  localparam logic [1:0] LVL_ADV    = 2'd2;

  localparam logic [1:0] SPEED_NORMAL = 2'b00;
  localparam logic [1:0] SPEED_INTER  = 2'b01;
  localparam logic [1:0] SPEED_ADV    = 2'b10;

  // Speed code that downstream logic uses for a given difficulty level.
  function automatic logic [1:0] speed_of(input logic [1:0] level);
    case (level)
      LVL_INTER: return SPEED_INTER;
      LVL_ADV:   return SPEED_ADV;
      default:   return SPEED_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/game_tick_controller_if.sv
// Player-control inputs and round-status outputs of the tick controller.
// The game core drives the controls (master); the controller answers (slave).
interface game_tick_controller_if;

  logic       Start;
  logic       Pause;
  logic       Hit;
  logic [1:0] Level;
  logic [1:0] GameSpeed;
  logic       Tick;
  logic       LevelUp;
  logic [5:0] TicksLeft;
  logic       Running;
  logic       Done;

  modport master (
    output Start, Pause, Hit,
    input  Level, GameSpeed, Tick, LevelUp, TicksLeft, Running, Done
  );

  modport slave (
    input  Start, Pause, Hit,
    output Level, GameSpeed, Tick, LevelUp, TicksLeft, Running, Done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Counts 0..period-1 while enabled and emits a registered one-cycle pulse
// after each wrap. `wrap` exposes the wrap condition of the current cycle so
// the owner can update its own state on the same edge the pulse is issued.
module tick_prescaler #(
  parameter int CNT_W = 26
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             wrap,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;

  assign wrap = enable && (cnt_q == period - CNT_W'(1));

  // Counter and tick pulse; clear resets the count but never swallows a wrap.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (clear || wrap) begin
        cnt_q <= '0;
      end else if (enable) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_tick_controller.sv
// Round sequencer: owns the difficulty level, paces the game tick by level,
// promotes on hits and ends the round after ROUND_TICKS ticks.
module game_tick_controller
  import game_pkg::*;
#(
  parameter int NORMAL_PERIOD  = 50_000_000,
  parameter int INTER_PERIOD   = 25_000_000,
  parameter int ADV_PERIOD     = 12_500_000,
  parameter int HITS_PER_LEVEL = 8,
  parameter int ROUND_TICKS    = 60,
  parameter int CNT_W          = 26
) (
  input  logic                   Clock,
  input  logic                   Reset,
  game_tick_controller_if.slave  bus
);

  localparam int               HIT_W      = $clog2(HITS_PER_LEVEL + 1);
  localparam logic [HIT_W-1:0] HIT_MAX    = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [5:0]       ROUND_INIT = 6'(ROUND_TICKS);

  state_t           state_q, state_d;
  logic [1:0]       level_q, level_d, speed_q;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [5:0]       ticks_q, ticks_d;
  logic             level_up_q, running_q, done_q;
  logic             in_round, presc_en, presc_clr, presc_wrap, presc_tick;
  logic             final_tick, promote;
  logic [CNT_W-1:0] period;

  // Tick period for the current level; a promotion clears the prescaler, so
  // the new period takes effect from count 0.
  always_comb begin
    case (level_q)
      LVL_INTER: period = CNT_W'(INTER_PERIOD);
      LVL_ADV:   period = CNT_W'(ADV_PERIOD);
      default:   period = CNT_W'(NORMAL_PERIOD);
    endcase
  end

  // The count advances in any cycle of a round whose Pause input is low, so
  // a wrap held off by Pause fires on the resume edge.
  assign in_round   = (state_q == S_Run) || (state_q == S_Pause);
  assign presc_en   = in_round && !bus.Pause;
  assign final_tick = presc_wrap && (ticks_q == 6'd1);

  tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .period (period),
    .wrap   (presc_wrap),
    .tick   (presc_tick)
  );

  // Next-state, round counter and hit/level bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a variable unassigned (which infers a latch).
    state_d   = state_q;
    level_d   = level_q;
    hits_d    = hits_q;
    ticks_d   = ticks_q;
    presc_clr = 1'b0;
    promote   = 1'b0;
    case (state_q)
      S_Idle, S_Done: begin
        if (bus.Start) begin
          state_d   = S_Run;
          presc_clr = 1'b1;
          hits_d    = '0;
          level_d   = LVL_NORMAL;
          ticks_d   = ROUND_INIT;
        end
      end
      S_Run, S_Pause: begin
        if (presc_wrap) begin
          ticks_d = ticks_q - 6'd1;
        end
        if (final_tick) begin
          state_d = S_Done;               // a hit on the last tick is lost
        end else if (bus.Pause) begin
          state_d = S_Pause;              // a hit while pausing is lost
        end else begin
          state_d = S_Run;
          if ((state_q == S_Run) && bus.Hit) begin
            if ((hits_q == HIT_MAX) && (level_q != LVL_ADV)) begin
              promote   = 1'b1;
              presc_clr = 1'b1;
              hits_d    = '0;
              level_d   = level_q + 2'd1;
            end else if (hits_q != HIT_MAX) begin
              hits_d = hits_q + HIT_W'(1);
            end
          end
        end
      end
      default: state_d = S_Idle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_Idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Round datapath and registered status outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      level_q    <= LVL_NORMAL;
      speed_q    <= SPEED_NORMAL;
      hits_q     <= '0;
      ticks_q    <= '0;
      level_up_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      level_q    <= level_d;
      speed_q    <= speed_of(level_d);
      hits_q     <= hits_d;
      ticks_q    <= ticks_d;
      level_up_q <= promote;
      running_q  <= (state_d == S_Run);
      done_q     <= (state_d == S_Done);
    end
  end

  assign bus.Level     = level_q;
  assign bus.GameSpeed = speed_q;
  assign bus.Tick      = presc_tick;
  assign bus.LevelUp   = level_up_q;
  assign bus.TicksLeft = ticks_q;
  assign bus.Running   = running_q;
  assign bus.Done      = done_q;

endmodule

// File: tb/tb_game_tick_controller.sv
// Bench for game_tick_controller with short periods. A cycle model pushes the
// expected outputs for each edge into a scoreboard queue; the entry is popped
// and compared once the edge has happened. Directed checks pin the edge
// numbers of ticks and promotions to fixed values.
module tb_game_tick_controller;

  localparam int NP = 4, IP = 3, AP = 2, H = 2, RT = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct {
    logic [1:0] level;
    logic [1:0] speed;
    logic       tick;
    logic       lu;
    logic [5:0] left;
    logic       run;
    logic       done;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  game_tick_controller_if bus ();

  game_tick_controller #(
    .NORMAL_PERIOD (NP),
    .INTER_PERIOD  (IP),
    .ADV_PERIOD    (AP),
    .HITS_PER_LEVEL(H),
    .ROUND_TICKS   (RT),
    .CNT_W         (3)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_no  = 0;
  exp_t sb[$];
  int   tick_log[$];
  int   lu_log[$];

  int m_state, m_cnt, m_hits, m_lvl, m_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_period(input int lvl);
    return (lvl == 0) ? NP : (lvl == 1) ? IP : AP;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_cnt   = 0;
    m_hits  = 0;
    m_lvl   = 0;
    m_left  = 0;
    sb.delete();
  endtask

  // Advance the model by one edge with the given inputs; queue the outputs.
  task automatic model_step(input logic s, input logic p, input logic h);
    exp_t e;
    bit   wrap;
    int   old;
    old  = m_state;
    e.tick = 1'b0;
    e.lu   = 1'b0;
    if (old == M_IDLE || old == M_DONE) begin
      if (s) begin
        m_state = M_RUN;
        m_cnt   = 0;
        m_hits  = 0;
        m_lvl   = 0;
        m_left  = RT;
      end
    end else begin
      wrap = !p && (m_cnt == m_period(m_lvl) - 1);
      if (!p) m_cnt = wrap ? 0 : m_cnt + 1;
      if (wrap) begin
        e.tick = 1'b1;
        m_left--;
      end
      if (wrap && m_left == 0) begin
        m_state = M_DONE;
      end else if (p) begin
        m_state = M_PAUSE;
      end else begin
        m_state = M_RUN;
        if (old == M_RUN && h) begin
          if (m_hits == H - 1 && m_lvl < 2) begin
            m_lvl++;
            m_hits = 0;
            m_cnt  = 0;
            e.lu   = 1'b1;
          end else if (m_hits < H - 1) begin
            m_hits++;
          end
        end
      end
    end
    e.level = 2'(m_lvl);
    e.speed = 2'(m_lvl);
    e.left  = 6'(m_left);
    e.run   = (m_state == M_RUN);
    e.done  = (m_state == M_DONE);
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, let the edge happen, compare against the model.
  task automatic cycle(input logic s, input logic p, input logic h);
    exp_t e;
    bus.Start = s;
    bus.Pause = p;
    bus.Hit   = h;
    model_step(s, p, h);
    @(posedge Clock);
    #1;
    edge_no++;
    if (bus.Tick === 1'b1) tick_log.push_back(edge_no);
    if (bus.LevelUp === 1'b1) lu_log.push_back(edge_no);
    if (sb.size() == 0) begin
      check($sformatf("sb_underflow@%0d", edge_no), 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check($sformatf("Level@%0d", edge_no),     32'(bus.Level),     32'(e.level));
      check($sformatf("GameSpeed@%0d", edge_no), 32'(bus.GameSpeed), 32'(e.speed));
      check($sformatf("Tick@%0d", edge_no),      32'(bus.Tick),      32'(e.tick));
      check($sformatf("LevelUp@%0d", edge_no),   32'(bus.LevelUp),   32'(e.lu));
      check($sformatf("TicksLeft@%0d", edge_no), 32'(bus.TicksLeft), 32'(e.left));
      check($sformatf("Running@%0d", edge_no),   32'(bus.Running),   32'(e.run));
      check($sformatf("Done@%0d", edge_no),      32'(bus.Done),      32'(e.done));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_Level"},     32'(bus.Level),     32'(0));
    check({tag, "_GameSpeed"}, 32'(bus.GameSpeed), 32'(0));
    check({tag, "_Tick"},      32'(bus.Tick),      32'(0));
    check({tag, "_LevelUp"},   32'(bus.LevelUp),   32'(0));
    check({tag, "_TicksLeft"}, 32'(bus.TicksLeft), 32'(0));
    check({tag, "_Running"},   32'(bus.Running),   32'(0));
    check({tag, "_Done"},      32'(bus.Done),      32'(0));
  endtask

  task automatic do_reset();
    Reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
    bus.Hit   = 1'b0;
    model_reset();
    @(posedge Clock);
    #1;
    check_all_zero("reset");
    Reset = 1'b1;
  endtask

  // Start a round: the Start edge is numbered 0.
  task automatic start_round();
    tick_log.delete();
    lu_log.delete();
    edge_no = -1;
    cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Pause = 1'b0;
    bus.Hit   = 1'b0;

    // Basic round: ticks after edges 4, 8, 12, 16, 20, then Done.
    do_reset();
    start_round();
    repeat (22) cycle(1'b0, 1'b0, 1'b0);
    begin
      int exp_ticks[5] = '{4, 8, 12, 16, 20};
      check("basic_tick_count", 32'(tick_log.size()), 32'(5));
      for (int i = 0; i < 5 && i < tick_log.size(); i++)
        check($sformatf("basic_tick_edge%0d", i), 32'(tick_log[i]), 32'(exp_ticks[i]));
    end
    check("basic_done", 32'(bus.Done), 32'(1));
    check("basic_running", 32'(bus.Running), 32'(0));

    // Promotion: hits at edges 1 and 2 promote to level 1, next tick at 5.
    do_reset();
    start_round();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("promo_lu_edge", 32'((lu_log.size() == 1) ? lu_log[0] : -1), 32'(2));
    check("promo_level1", 32'(bus.Level), 32'(1));
    check("promo_speed1", 32'(bus.GameSpeed), 32'(1));
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("promo_next_tick", 32'((tick_log.size() >= 1) ? tick_log[0] : -1), 32'(5));
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("promo_level2", 32'(bus.Level), 32'(2));
    check("promo_lu_count2", 32'(lu_log.size()), 32'(2));
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    check("promo_sat_level", 32'(bus.Level), 32'(2));
    check("promo_sat_lu_count", 32'(lu_log.size()), 32'(2));
    repeat (6) cycle(1'b0, 1'b0, 1'b0);

    // Pause raised after edge 2, dropped after edge 6; hit during the pause.
    do_reset();
    start_round();
    cycle(1'b0, 1'b0, 1'b1);          // edge 1: hit counter to 1
    cycle(1'b0, 1'b0, 1'b0);          // edge 2
    cycle(1'b0, 1'b1, 1'b0);          // edge 3
    cycle(1'b0, 1'b1, 1'b1);          // edge 4: hit must be dropped
    cycle(1'b0, 1'b1, 1'b0);          // edge 5
    cycle(1'b0, 1'b1, 1'b0);          // edge 6
    cycle(1'b0, 1'b0, 1'b0);          // edge 7: resume
    cycle(1'b0, 1'b0, 1'b0);          // edge 8: tick
    check("pause_first_tick", 32'((tick_log.size() >= 1) ? tick_log[0] : -1), 32'(8));
    check("pause_no_lu", 32'(lu_log.size()), 32'(0));
    check("pause_level", 32'(bus.Level), 32'(0));
    cycle(1'b0, 1'b0, 1'b1);          // edge 9: counter kept its 1, promotes
    check("pause_resume_lu", 32'(lu_log.size()), 32'(1));
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Collisions: promoting hit on wrap edge 4, then a hit on the final tick.
    do_reset();
    start_round();
    cycle(1'b0, 1'b0, 1'b0);          // edge 1
    cycle(1'b0, 1'b0, 1'b0);          // edge 2
    cycle(1'b0, 1'b0, 1'b1);          // edge 3
    cycle(1'b0, 1'b0, 1'b1);          // edge 4: wrap + promotion
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("coll_tick_edge", 32'((tick_log.size() >= 1) ? tick_log[0] : -1), 32'(4));
    check("coll_lu_edge", 32'((lu_log.size() >= 1) ? lu_log[0] : -1), 32'(4));
    check("coll_next_tick", 32'((tick_log.size() >= 2) ? tick_log[1] : -1), 32'(7));
    repeat (7) cycle(1'b0, 1'b0, 1'b0);   // edges 8..14
    cycle(1'b0, 1'b0, 1'b1);          // edge 15: counter to 1
    cycle(1'b0, 1'b0, 1'b1);          // edge 16: final tick wins
    check("coll_final_done", 32'(bus.Done), 32'(1));
    check("coll_final_level", 32'(bus.Level), 32'(1));
    check("coll_final_lu", 32'(lu_log.size()), 32'(1));

    // Restart from Done, ignored Start in Run, then asynchronous reset.
    start_round();
    check("restart_level", 32'(bus.Level), 32'(0));
    check("restart_left", 32'(bus.TicksLeft), 32'(5));
    cycle(1'b0, 1'b0, 1'b0);          // edge 1
    cycle(1'b1, 1'b0, 1'b0);          // edge 2: Start ignored
    cycle(1'b0, 1'b0, 1'b0);          // edge 3
    cycle(1'b0, 1'b0, 1'b0);          // edge 4: tick
    check("restart_tick_edge", 32'((tick_log.size() >= 1) ? tick_log[0] : -1), 32'(4));
    check("restart_left_after_tick", 32'(bus.TicksLeft), 32'(4));
    cycle(1'b0, 1'b0, 1'b1);          // edge 5: hit, counter to 1
    #2;
    Reset = 1'b0;                     // mid-cycle, no clock edge involved
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
